// File: rtl/sift_out_pkg.sv
// -----------------------------------------------------------------------------
// sift_out_pkg
// Shared constants and helpers for the sift-out N-module redundancy voter.
//   MAX_N      : largest supported module count
//   FILT_CNT_W : width of the per-module transient mismatch counter
//   POP_W      : width of a population count over MAX_N bits
//   popcount() : number of set bits in a MAX_N-bit vector
// -----------------------------------------------------------------------------
package sift_out_pkg;

    localparam int MAX_N      = 16;
    localparam int FILT_CNT_W = 4;
    localparam int POP_W      = $clog2(MAX_N + 1);

    // Counts set bits; callers zero-extend narrower vectors to MAX_N bits.
    function automatic logic [POP_W-1:0] popcount(input logic [MAX_N-1:0] v);
        logic [POP_W-1:0] acc;
        acc = {POP_W{1'b0}};
        for (int i = 0; i < MAX_N; i++) begin
            acc = acc + {{(POP_W-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/sift_out_nmr_voter_if.sv
// -----------------------------------------------------------------------------
// sift_out_nmr_voter_if
// Bundles the voter's sample input, clear and result signals.
//   clr        : synchronous clear of all exclusions
//   in_valid   : in_data carries a sample this cycle
//   in_data    : N module outputs, module i at [i*W +: W]
//   out_valid  : one-cycle strobe per accepted sample
//   out_data   : sifted result
//   excl       : sticky per-module exclusion flags
//   excl_count : number of excluded modules
//   disagree   : last two active modules mismatched
// Modports: master = producer/consumer side, slave = voter side.
// -----------------------------------------------------------------------------
interface sift_out_nmr_voter_if #(
    parameter int N = 3,
    parameter int W = 8
);
    logic                       clr;
    logic                       in_valid;
    logic [N*W-1:0]             in_data;
    logic                       out_valid;
    logic [W-1:0]               out_data;
    logic [N-1:0]               excl;
    logic [$clog2(N+1)-1:0]     excl_count;
    logic                       disagree;

    modport master (
        output clr, in_valid, in_data,
        input  out_valid, out_data, excl, excl_count, disagree
    );

    modport slave (
        input  clr, in_valid, in_data,
        output out_valid, out_data, excl, excl_count, disagree
    );
endinterface

// File: rtl/sift_out_detector.sv
// -----------------------------------------------------------------------------
// sift_out_detector
// Combinational pairwise comparator, fault detector and collector.
//   in_data       : N module outputs, module i at [i*W +: W]
//   excl          : registered exclusion flags (active set = ~excl)
//   f             : modules disagreeing with every other active module
//   sel           : lowest-index active module not flagged in f
//   disagree_next : exactly two active modules and they mismatch
// -----------------------------------------------------------------------------
module sift_out_detector
    import sift_out_pkg::*;
#(
    parameter int N  = 3,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   excl,
    output logic [N-1:0]   f,
    output logic [SW-1:0]  sel,
    output logic           disagree_next
);

    logic [W-1:0]     data_s [N];
    logic [N-1:0]     active_s;
    logic [N-1:0]     agree_s;
    logic [N-1:0]     raw_f_s;
    logic [N-1:0]     lowest_s;
    logic [N-1:0]     cand_s;
    logic [POP_W-1:0] n_active_s;
    logic             multi_s;
    logic             pair_s;
    logic             all_flag_s;

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign data_s[g] = in_data[g*W +: W];
    end

    assign active_s   = ~excl;
    assign n_active_s = popcount(MAX_N'(active_s));
    assign multi_s    = (n_active_s >= POP_W'(2));
    assign pair_s     = (n_active_s == POP_W'(2));
    // One-hot of the lowest-index active module.
    assign lowest_s   = active_s & (~active_s + {{(N-1){1'b0}}, 1'b1});

    // Marks modules that match at least one other active module.
    always_comb begin
        agree_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                agree_s[i] = agree_s[i] |
                             ((j != i) && active_s[j] && (data_s[i] == data_s[j]));
            end
        end
    end

    assign raw_f_s    = active_s & ~agree_s & {N{multi_s}};
    // Every active module disagrees with every other: nobody can be trusted
    // more than another, so the lowest-index one is kept alive.
    assign all_flag_s = (raw_f_s == active_s);
    assign disagree_next = pair_s & (|raw_f_s);

    // Final fault vector: a lone pair cannot assign blame, and the last
    // survivor is never flagged.
    always_comb begin
        f = raw_f_s;
        if (pair_s) begin
            f = {N{1'b0}};
        end else if (all_flag_s) begin
            f = raw_f_s & ~lowest_s;
        end else begin
            f = raw_f_s;
        end
    end

    assign cand_s = active_s & ~f;

    // Priority pick of the lowest-index surviving module.
    always_comb begin
        sel = {SW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            sel = cand_s[i] ? SW'(i) : sel;
        end
    end

endmodule

// File: rtl/sift_out_nmr_voter.sv
// -----------------------------------------------------------------------------
// sift_out_nmr_voter
// N-module, W-bit sift-out redundancy voter with sticky exclusion.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sift_out_nmr_voter_if.slave (clr, in_valid, in_data in;
//         out_valid, out_data, excl, excl_count, disagree out)
// Optional build macro SIFT_OUT_TRANSIENT_FILTER_EN: a module is excluded
// only after FILT_DEPTH consecutive valid mismatching samples; otherwise the
// first mismatch excludes it and FILT_DEPTH is ignored.
// -----------------------------------------------------------------------------
module sift_out_nmr_voter
    import sift_out_pkg::*;
#(
    parameter int N          = 3,
    parameter int W          = 8,
    parameter int FILT_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    sift_out_nmr_voter_if.slave bus
);

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  f_s;
    logic [N-1:0]  set_s;
    logic [SW-1:0] sel_s;
    logic          disagree_next_s;
    logic [W-1:0]  result_s;
    logic [N-1:0]  excl_next_s;

    logic [N-1:0]  excl_r;
    logic [CW-1:0] excl_count_r;
    logic          out_valid_r;
    logic [W-1:0]  out_data_r;
    logic          disagree_r;

    sift_out_detector #(.N(N), .W(W), .SW(SW)) u_detector (
        .in_data       (bus.in_data),
        .excl          (excl_r),
        .f             (f_s),
        .sel           (sel_s),
        .disagree_next (disagree_next_s)
    );

    assign result_s = bus.in_data[int'(sel_s)*W +: W];

`ifdef SIFT_OUT_TRANSIENT_FILTER_EN
    logic [FILT_CNT_W-1:0] cnt_r      [N];
    logic [FILT_CNT_W-1:0] cnt_next_s [N];

    // Filter: exclusion fires on the mismatch that completes FILT_DEPTH in a row.
    always_comb begin
        set_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            set_s[i] = f_s[i] &
                       (({1'b0, cnt_r[i]} + {{FILT_CNT_W{1'b0}}, 1'b1}) >=
                        (FILT_CNT_W+1)'(FILT_DEPTH));
            if (!f_s[i]) begin
                cnt_next_s[i] = {FILT_CNT_W{1'b0}};
            end else if (&cnt_r[i]) begin
                cnt_next_s[i] = cnt_r[i];
            end else begin
                cnt_next_s[i] = cnt_r[i] + {{(FILT_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Mismatch counters advance only on valid samples; clr wipes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) cnt_r[i] <= {FILT_CNT_W{1'b0}};
        end else if (bus.clr) begin
            for (int i = 0; i < N; i++) cnt_r[i] <= {FILT_CNT_W{1'b0}};
        end else if (bus.in_valid) begin
            for (int i = 0; i < N; i++) cnt_r[i] <= cnt_next_s[i];
        end
    end
`else
    assign set_s = f_s;
`endif

    // Next exclusion state: clr wins over new exclusions.
    always_comb begin
        excl_next_s = excl_r;
        if (bus.clr) begin
            excl_next_s = {N{1'b0}};
        end else if (bus.in_valid) begin
            excl_next_s = excl_r | set_s;
        end else begin
            excl_next_s = excl_r;
        end
    end

    // Exclusion flags and their population count move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excl_r       <= {N{1'b0}};
            excl_count_r <= {CW{1'b0}};
        end else begin
            excl_r       <= excl_next_s;
            excl_count_r <= CW'(popcount(MAX_N'(excl_next_s)));
        end
    end

    // Result registers: one-cycle latency, hold when no sample arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            disagree_r  <= 1'b0;
        end else if (bus.in_valid) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            disagree_r  <= disagree_next_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.excl       = excl_r;
    assign bus.excl_count = excl_count_r;
    assign bus.disagree   = disagree_r;

endmodule

// File: tb/tb_sift_out_nmr_voter.sv
// -----------------------------------------------------------------------------
// tb_sift_out_nmr_voter
// Self-checking bench: an N=3 and an N=5 voter see the same module values
// (the N=3 one uses modules 0..2). A behavioural model tracks the expected
// outputs of both; directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_sift_out_nmr_voter;

`ifdef SIFT_OUT_TRANSIENT_FILTER_EN
    localparam int  FD      = 2;
    localparam logic FILT_ON = 1'b1;
`else
    localparam int  FD      = 1;
    localparam logic FILT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run_chk = 1'b0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    sift_out_nmr_voter_if #(.N(3), .W(8)) bus3 ();
    sift_out_nmr_voter_if #(.N(5), .W(8)) bus5 ();

    sift_out_nmr_voter #(.N(3), .W(8), .FILT_DEPTH(2)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave));
    sift_out_nmr_voter #(.N(5), .W(8), .FILT_DEPTH(2)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5.slave));

    // stimulus values for modules 0..4
    logic [7:0] dv [5];

    // ---------------- behavioural model ----------------
    logic [15:0] m_excl [2];
    int          m_cnt  [2][16];
    logic        m_ov   [2];
    logic [7:0]  m_od   [2];
    logic        m_dis  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_excl[k] = 16'h0; m_ov[k] = 1'b0; m_od[k] = 8'h00; m_dis[k] = 1'b0;
            for (int i = 0; i < 16; i++) m_cnt[k][i] = 0;
        end
    endtask

    task automatic model_step(input int k, input int n, input logic v,
                              input logic c, input logic [79:0] din);
        logic [7:0] d [16];
        logic       fl [16];
        int act_n, unflagged, sel;
        logic dis;
        for (int i = 0; i < n; i++) d[i] = din[i*8 +: 8];
        act_n = 0;
        for (int i = 0; i < n; i++) if (!m_excl[k][i]) act_n++;
        // a module is suspect when no other active module shares its value
        for (int i = 0; i < n; i++) begin
            fl[i] = 1'b0;
            if (!m_excl[k][i] && act_n >= 2) begin
                fl[i] = 1'b1;
                for (int j = 0; j < n; j++)
                    if (j != i && !m_excl[k][j] && d[j] == d[i]) fl[i] = 1'b0;
            end
        end
        dis = 1'b0;
        if (act_n == 2) begin
            for (int i = 0; i < n; i++) begin
                if (fl[i]) dis = 1'b1;
                fl[i] = 1'b0;
            end
        end
        unflagged = 0;
        for (int i = 0; i < n; i++) if (!m_excl[k][i] && !fl[i]) unflagged++;
        if (unflagged == 0) begin
            for (int i = n - 1; i >= 0; i--) if (!m_excl[k][i]) sel = i;
            fl[sel] = 1'b0;
        end
        sel = -1;
        for (int i = n - 1; i >= 0; i--) if (!m_excl[k][i] && !fl[i]) sel = i;
        if (c) begin
            m_excl[k] = 16'h0;
            for (int i = 0; i < 16; i++) m_cnt[k][i] = 0;
        end else if (v) begin
            for (int i = 0; i < n; i++) begin
                if (fl[i]) begin
                    if (m_cnt[k][i] + 1 >= FD) m_excl[k][i] = 1'b1;
                    m_cnt[k][i] = (m_cnt[k][i] < 15) ? m_cnt[k][i] + 1 : 15;
                end else begin
                    m_cnt[k][i] = 0;
                end
            end
        end
        if (v) begin
            m_ov[k] = 1'b1; m_od[k] = d[sel]; m_dis[k] = dis;
        end else begin
            m_ov[k] = 1'b0;
        end
    endtask

    // model advances on the same edges as the DUTs
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, 3, bus3.in_valid, bus3.clr, 80'(bus3.in_data));
            model_step(1, 5, bus5.in_valid, bus5.clr, 80'(bus5.in_data));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    endtask

    // compare both DUTs against the model every cycle, away from the edge
    always @(negedge clk) begin
        if (run_chk && !rst) begin
            chk("d3_out_valid",  32'(bus3.out_valid),  32'(m_ov[0]));
            chk("d3_out_data",   32'(bus3.out_data),   32'(m_od[0]));
            chk("d3_excl",       32'(bus3.excl),       32'(m_excl[0]));
            chk("d3_excl_count", 32'(bus3.excl_count), 32'($countones(m_excl[0])));
            chk("d3_disagree",   32'(bus3.disagree),   32'(m_dis[0]));
            chk("d5_out_valid",  32'(bus5.out_valid),  32'(m_ov[1]));
            chk("d5_out_data",   32'(bus5.out_data),   32'(m_od[1]));
            chk("d5_excl",       32'(bus5.excl),       32'(m_excl[1]));
            chk("d5_excl_count", 32'(bus5.excl_count), 32'($countones(m_excl[1])));
            chk("d5_disagree",   32'(bus5.disagree),   32'(m_dis[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_all(input logic [7:0] x);
        for (int i = 0; i < 5; i++) dv[i] = x;
    endtask

    // apply values at the falling edge, then wait until just after the rise
    task automatic cyc(input logic v, input logic c);
        @(negedge clk);
        bus3.in_valid = v; bus3.clr = c;
        bus5.in_valid = v; bus5.clr = c;
        for (int i = 0; i < 3; i++) bus3.in_data[i*8 +: 8] = dv[i];
        for (int i = 0; i < 5; i++) bus5.in_data[i*8 +: 8] = dv[i];
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ov3"},  32'(bus3.out_valid), 32'h0);
        chk({tag, "_od3"},  32'(bus3.out_data),  32'h0);
        chk({tag, "_ex3"},  32'(bus3.excl),      32'h0);
        chk({tag, "_cnt5"}, 32'(bus5.excl_count), 32'h0);
        chk({tag, "_ex5"},  32'(bus5.excl),      32'h0);
        chk({tag, "_dis5"}, 32'(bus5.disagree),  32'h0);
    endtask

    initial begin
        set_all(8'h00);
        bus3.in_valid = 1'b0; bus3.clr = 1'b0; bus3.in_data = '0;
        bus5.in_valid = 1'b0; bus5.clr = 1'b0; bus5.in_data = '0;
        #1 rst = 1'b1;
        #11;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        run_chk = 1'b1;

        // all equal: result is the common value, no exclusions
        set_all(8'h5A);
        for (int n = 0; n < 4; n++) begin
            cyc(1'b1, 1'b0);
            chk("eq_data", 32'(bus3.out_data), 32'h5A);
            chk("eq_excl", 32'(bus3.excl), 32'h0);
            chk("eq_dis",  32'(bus3.disagree), 32'h0);
        end

        // module 1 faulty: masked immediately, excluded (after filter depth)
        set_all(8'h12); dv[1] = 8'hFF;
        cyc(1'b1, 1'b0);
        chk("f1_data", 32'(bus3.out_data), 32'h12);
        chk("f1_excl_first", 32'(bus3.excl), FILT_ON ? 32'h0 : 32'h2);
        cyc(1'b1, 1'b0);
        chk("f1_excl", 32'(bus3.excl), 32'h2);
        chk("f1_cnt",  32'(bus3.excl_count), 32'h1);
        set_all(8'h33);
        cyc(1'b1, 1'b0);
        chk("f1_sticky", 32'(bus3.excl), 32'h2);
        chk("f1_data2",  32'(bus3.out_data), 32'h33);

        // two survivors disagree: no blame, lowest index delivered
        set_all(8'h12); dv[1] = 8'hEE; dv[2] = 8'h00;
        cyc(1'b1, 1'b0);
        chk("pair_dis",  32'(bus3.disagree), 32'h1);
        chk("pair_excl", 32'(bus3.excl), 32'h2);
        chk("pair_data", 32'(bus3.out_data), 32'h12);

        // idle cycle: valid drops, everything else holds
        cyc(1'b0, 1'b0);
        chk("idle_ov",   32'(bus3.out_valid), 32'h0);
        chk("idle_data", 32'(bus3.out_data), 32'h12);

        // clr wipes exclusions
        set_all(8'h33);
        cyc(1'b1, 1'b1);
        chk("clr_excl", 32'(bus3.excl), 32'h0);
        chk("clr_cnt",  32'(bus3.excl_count), 32'h0);

        // N=5: faults on modules 4, 3, 2 in turn
        for (int m = 4; m >= 2; m--) begin
            set_all(8'h20); dv[m] = 8'hF0;
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b0);
        end
        chk("n5_excl", 32'(bus5.excl), 32'h1C);
        chk("n5_cnt",  32'(bus5.excl_count), 32'h3);
        set_all(8'h20); dv[0] = 8'h01; dv[1] = 8'h02;
        for (int n = 0; n < 3; n++) cyc(1'b1, 1'b0);
        chk("n5_last_excl", 32'(bus5.excl), 32'h1C);
        chk("n5_last_dis",  32'(bus5.disagree), 32'h1);
        chk("n5_last_data", 32'(bus5.out_data), 32'h01);

        // transient filter pattern on module 0: bad, good, bad, bad
        set_all(8'h44);
        cyc(1'b1, 1'b1);
        dv[0] = 8'hBB;
        cyc(1'b1, 1'b0);
        chk("flt_data1", 32'(bus3.out_data), 32'h44);
        chk("flt_excl1", 32'(bus3.excl), FILT_ON ? 32'h0 : 32'h1);
        dv[0] = 8'h44;
        cyc(1'b1, 1'b0);
        chk("flt_data2", 32'(bus3.out_data), 32'h44);
        dv[0] = 8'hBB;
        cyc(1'b1, 1'b0);
        chk("flt_data3", 32'(bus3.out_data), 32'h44);
        chk("flt_excl3", 32'(bus3.excl), FILT_ON ? 32'h0 : 32'h1);
        cyc(1'b1, 1'b0);
        chk("flt_data4", 32'(bus3.out_data), 32'h44);
        chk("flt_excl4", 32'(bus3.excl), 32'h1);

        // randomized traffic with a mid-stream asynchronous reset
        for (int n = 0; n < 400; n++) begin
            logic [7:0] base;
            base = 8'($urandom);
            for (int i = 0; i < 5; i++)
                dv[i] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : base;
            cyc(($urandom_range(0, 4) != 0), ($urandom_range(0, 15) == 0));
            if (n == 200) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1;
                chk_zero("midrst");
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        run_chk = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
